// File: rtl/cipher_serial_link.sv
// cipher_serial_link
//   Full-duplex encrypted serial link between a character stream and a one-bit
//   line. Characters are permuted/inverted and XORed with a runtime-loadable key,
//   then framed as start(0) + DATA_WIDTH bits LSB first + stop(1). The link stays
//   disabled until the correct password is presented; MAX_TRIES wrong attempts
//   lock it until reset.
//
//   Ports
//     clock, reset         rising-edge clock, synchronous active-high reset
//     pwd_in, pwd_strobe   password candidate and its evaluate strobe
//     enabled, locked      unlock / lockout status
//     key_load, key_in     key update (only while enabled and both sides idle)
//     tx_data/valid/ready  plaintext handshake into the transmitter
//     tx_line              serial out, idles high
//     rx_line              serial in
//     rx_data, rx_cipher   last decrypted character and its raw ciphertext
//     rx_valid             one-cycle pulse on a good frame
//     rx_frame_err         one-cycle pulse on a bad stop bit
//
//   TX state | meaning
//   ---------+------------------------------------------------
//   TX_IDLE  | line high, waiting for an accepted character
//   TX_START | driving the start bit (0)
//   TX_DATA  | shifting ciphertext out LSB first
//   TX_STOP  | driving the stop bit (1); may accept the next one
//
//   RX state | meaning
//   ---------+------------------------------------------------
//   RX_IDLE  | sampling the line for a start bit
//   RX_DATA  | shifting ciphertext in LSB first
//   RX_STOP  | sampling the stop bit, then pulse valid or error
module cipher_serial_link #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] KEY_INIT   = 8'd43,
    parameter int                    PWD_WIDTH  = 4,
    parameter logic [PWD_WIDTH-1:0]  PASSWORD   = 4'b0101,
    parameter int                    MAX_TRIES  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PWD_WIDTH-1:0]  pwd_in,
    input  logic                  pwd_strobe,
    output logic                  enabled,
    output logic                  locked,
    input  logic                  key_load,
    input  logic [DATA_WIDTH-1:0] key_in,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_line,
    input  logic                  rx_line,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [DATA_WIDTH-1:0] rx_cipher,
    output logic                  rx_valid,
    output logic                  rx_frame_err
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

    // Even bits inverted, odd bits below the MSB rotate down by one odd slot
    // (top odd slot takes bit 1), MSB untouched, then key XOR.
    function automatic logic [DATA_WIDTH-1:0] encrypt(input logic [DATA_WIDTH-1:0] m,
                                                      input logic [DATA_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] p;
        p = m;
        for (int i = 0; i < DATA_WIDTH; i += 2) p[i] = ~m[i];
        for (int i = 1; i < DATA_WIDTH - 3; i += 2) p[i] = m[i + 2];
        p[DATA_WIDTH-3] = m[1];
        return p ^ k;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] decrypt(input logic [DATA_WIDTH-1:0] c,
                                                      input logic [DATA_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] m;
        x = c ^ k;
        m = x;
        for (int i = 0; i < DATA_WIDTH; i += 2) m[i] = ~x[i];
        for (int i = 1; i < DATA_WIDTH - 3; i += 2) m[i + 2] = x[i];
        m[1] = x[DATA_WIDTH-3];
        return m;
    endfunction

    logic                  enabled_q, enabled_d;
    logic                  locked_q, locked_d;
    logic [TRY_W-1:0]      tries_q, tries_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;

    tx_state_t             tx_state_q, tx_state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;

    rx_state_t             rx_state_q, rx_state_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0] rx_cipher_q, rx_cipher_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_err_q, rx_err_d;

    logic                  tx_accept;
    logic [TRY_W-1:0]      tries_inc;

    assign tx_ready  = enabled_q && (tx_state_q == TX_IDLE || tx_state_q == TX_STOP);
    assign tx_accept = tx_valid && tx_ready;
    assign tries_inc = tries_q + TRY_W'(1);

    // Unlock, lockout and key register
    always_comb begin
        enabled_d = enabled_q;
        locked_d  = locked_q;
        tries_d   = tries_q;
        key_d     = key_q;
        if (pwd_strobe && !enabled_q && !locked_q) begin
            if (pwd_in == PASSWORD) begin
                enabled_d = 1'b1;
            end else begin
                tries_d = tries_inc;
                if (tries_inc == TRY_MAX) locked_d = 1'b1;
            end
        end
        // A same-cycle TX accept already latched E(tx_data) with key_q.
        if (key_load && enabled_q && tx_state_q == TX_IDLE && rx_state_q == RX_IDLE)
            key_d = key_in;
    end

    // Transmitter
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_line    = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_d = TX_START;
                    tx_sh_d    = encrypt(tx_data, key_q);
                end
            end
            TX_START: begin
                tx_line    = 1'b0;
                tx_cnt_d   = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_line  = tx_sh_q[0];
                tx_sh_d  = {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_cnt_q == CNT_LAST) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_accept) begin
                    tx_state_d = TX_START;
                    tx_sh_d    = encrypt(tx_data, key_q);
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Receiver
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_sh_d     = rx_sh_q;
        rx_cnt_d    = rx_cnt_q;
        rx_data_d   = rx_data_q;
        rx_cipher_d = rx_cipher_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (enabled_q && !rx_line) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = '0;
                end
            end
            RX_DATA: begin
                rx_sh_d  = {rx_line, rx_sh_q[DATA_WIDTH-1:1]};
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q == CNT_LAST) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_line) begin
                    rx_valid_d  = 1'b1;
                    rx_cipher_d = rx_sh_q;
                    rx_data_d   = decrypt(rx_sh_q, key_q);
                end else begin
                    rx_err_d = 1'b1;
                end
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enabled_q   <= 1'b0;
            locked_q    <= 1'b0;
            tries_q     <= '0;
            key_q       <= KEY_INIT;
            tx_state_q  <= TX_IDLE;
            tx_sh_q     <= '0;
            tx_cnt_q    <= '0;
            rx_state_q  <= RX_IDLE;
            rx_sh_q     <= '0;
            rx_cnt_q    <= '0;
            rx_data_q   <= '0;
            rx_cipher_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            enabled_q   <= enabled_d;
            locked_q    <= locked_d;
            tries_q     <= tries_d;
            key_q       <= key_d;
            tx_state_q  <= tx_state_d;
            tx_sh_q     <= tx_sh_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_state_q  <= rx_state_d;
            rx_sh_q     <= rx_sh_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_cipher_q <= rx_cipher_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign enabled      = enabled_q;
    assign locked       = locked_q;
    assign rx_data      = rx_data_q;
    assign rx_cipher    = rx_cipher_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_err_q;

endmodule

// File: doc/cipher_serial_link.md
Name: cipher_serial_link

Overview:
Parametrised full-duplex encrypted serial link. It generalises the fixed 8-bit messenger to DATA_WIDTH, replaces free-running load pulses with valid/ready handshakes, and adds start/stop framing with frame-error detection. It also adds a runtime-loadable key and password gating with lockout. It sits between the keyboard/monitor character streams and the physical one-bit line.

Parameters:
DATA_WIDTH, 8, character width; must be even and >= 4
KEY_INIT, 8'd43, key value after reset (DATA_WIDTH bits)
PWD_WIDTH, 4, password width
PASSWORD, 4'b0101, unlock password
MAX_TRIES, 3, failed unlock attempts before lockout

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pwd_in  in  PWD_WIDTH  password candidate
pwd_strobe  in  1  evaluate pwd_in this cycle
enabled  out  1  link unlocked
locked  out  1  MAX_TRIES failures reached
key_load  in  1  load key_in
key_in  in  DATA_WIDTH  new key
tx_data  in  DATA_WIDTH  plaintext character
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter can accept
tx_line  out  1  serial out, idles high
rx_line  in  1  serial in
rx_data  out  DATA_WIDTH  decrypted character
rx_cipher  out  DATA_WIDTH  raw received ciphertext
rx_valid  out  1  one-cycle pulse, rx_data/rx_cipher valid
rx_frame_err  out  1  one-cycle pulse, bad stop bit

Behaviour:
- Reset values: enabled=0, locked=0, tries=0, key=KEY_INIT, tx_ready=0, tx_line=1, rx_data=0, rx_cipher=0, rx_valid=0, rx_frame_err=0. Both FSMs return to IDLE.
- Reset mid-frame aborts the frame. tx_line is 1 on the next cycle, and a partial RX frame is discarded with no pulses.
- Unlock:
  - pwd_strobe while !enabled && !locked: on a match, enabled=1 next cycle; on a mismatch, tries+1.
  - When tries reaches MAX_TRIES, locked=1. A locked block ignores pwd_strobe until reset.
  - pwd_strobe while enabled has no effect. Only reset clears enabled.
- Encrypt E(m), with W=DATA_WIDTH:
  - Even bits 0,2,...,W-2 are inverted.
  - Odd bits 1,3,...,W-3 rotate among themselves: the new odd slot k takes the old odd slot k+2, and the top slot W-3 takes old bit 1.
  - Bit W-1 passes through unchanged.
  - The result is XORed with key.
- Decrypt D(c): XOR with key, then apply the inverse permutation and the inversions. The MSB is recovered from c^key, so D(E(m))=m for all m and keys.
- Key load:
  - key_load is accepted only when enabled, TX is in IDLE and RX is in IDLE. Otherwise it is ignored.
  - The new key applies from the next cycle.
  - If a TX accept happens in the same cycle as key_load, that frame uses the old key.
- TX FSM (IDLE, START, DATA, STOP):
  - tx_ready=enabled && (IDLE || STOP).
  - Accept on tx_valid && tx_ready. E(tx_data) is latched at the accept.
  - The line carries one bit per clock: START (0) for 1 cycle, DATA for W cycles LSB first, STOP (1) for 1 cycle.
  - Accept at cycle N gives the start bit at N+1, data at N+2..N+W+1 and stop at N+W+2.
  - An accept during STOP gives back-to-back frames, with the next start bit at N+W+3.
  - tx_valid is ignored when !enabled.
- RX FSM (IDLE, DATA, STOP):
  - While enabled, IDLE samples rx_line each cycle. A 0 starts a frame, W data bits are then sampled LSB first, and then the stop bit is sampled.
  - If stop=1: on the cycle after the stop sample, rx_cipher=ciphertext, rx_data=D(ciphertext) and rx_valid=1 for one cycle.
  - If stop=0: rx_frame_err=1 for one cycle, rx_data and rx_cipher hold their old values, and the FSM returns to IDLE.
  - rx_line is ignored when !enabled.
  - Loopback latency: a TX accept at N gives rx_valid at N+W+3.
- rx_data and rx_cipher hold their value between pulses.

Test Plan:
- Reset, then pwd_strobe with pwd_in=4'b0101 -> enabled=1 next cycle; tx_ready=1; tx_line=1.
- Three strobes with 4'b1111 -> locked=1 after the third; a subsequent 4'b0101 strobe leaves enabled=0; reset clears locked.
- W=8, key 0x2B, tx_data=0x41 accepted at N -> tx_line from N+1: 0,1,1,1,1,1,1,0,0,1 (ciphertext 0x3F); tx_ready=0 during N+1..N+9, 1 at N+10.
- Loopback tx_line->rx_line, send 0x41 then 0x5A back-to-back -> rx_valid at N+11 with rx_data=0x41 and rx_cipher=0x3F, then a second pulse 10 cycles later with rx_data=0x5A; there is no idle cycle between the frames.
- key_load key_in=0x00 while idle, loopback 0x41 -> tx ciphertext 0x14 and rx_data=0x41. Repeat the key_load mid-frame -> it is ignored and the key stays 0x00.
- Drive rx_line frame start=0, data 0x3F, stop=0 -> rx_frame_err pulse, no rx_valid, rx_data unchanged. Assert reset mid-frame -> no pulses, and tx_line=1 on the next cycle.
